// File: rtl/prt_seq_pkg.sv
// Shared types and constants for the PRT transaction sequencer.
// Holds the write/read FSM state encodings and the command opcode values.
package prt_seq_pkg;

    typedef enum logic [2:0] {
        W_IDLE,
        W_DATA,
        W_DRAIN,
        W_FINISH,
        W_DONE
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_INVAL
    } rd_state_t;

    localparam logic OP_FWD  = 1'b0;
    localparam logic OP_DROP = 1'b1;

    function automatic int slot_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/prt_txn_sequencer.sv
// Sole PRT master: write engine stores ingress packets into free slots, read engine forwards/drops slots.
// Latency: write N beats -> N+2 cycles to wr_done; forward first beat 2 cycles after accept; stalls hold state.
module prt_txn_sequencer
    import prt_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 16,
    parameter int MAX_BEATS  = 64,
    localparam int SW = slot_width(NUM_SLOTS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  wr_done_valid,
    input  logic                  wr_done_ready,
    output logic [SW-1:0]         wr_done_slot,
    output logic                  wr_done_err,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SW-1:0]         cmd_slot,
    input  logic                  cmd_drop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  cmd_done,
    output logic                  EN_start_writing_prt_entry,
    input  logic                  RDY_start_writing_prt_entry,
    input  logic [SW-1:0]         start_writing_prt_entry,
    output logic                  EN_write_prt_entry,
    input  logic                  RDY_write_prt_entry,
    output logic [DATA_WIDTH-1:0] write_prt_entry_data,
    output logic                  EN_finish_writing_prt_entry,
    input  logic                  RDY_finish_writing_prt_entry,
    output logic                  EN_invalidate_prt_entry,
    input  logic                  RDY_invalidate_prt_entry,
    output logic [SW-1:0]         invalidate_prt_entry_slot,
    output logic                  EN_start_reading_prt_entry,
    input  logic                  RDY_start_reading_prt_entry,
    output logic [SW-1:0]         start_reading_prt_entry_slot,
    output logic                  EN_read_prt_entry,
    input  logic                  RDY_read_prt_entry,
    input  logic [DATA_WIDTH:0]   read_prt_entry,
    input  logic                  is_prt_slot_free,
    input  logic                  RDY_is_prt_slot_free
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] BEAT_LIM = BW'(MAX_BEATS - 1);

    wr_state_t       wr_state_q, wr_state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            err_q, err_d;

    rd_state_t       rd_state_q, rd_state_d;
    logic [SW-1:0]   rd_slot_q, rd_slot_d;

    // ---------------- write engine ----------------
    always_comb begin
        wr_state_d                  = wr_state_q;
        slot_d                      = slot_q;
        beat_cnt_d                  = beat_cnt_q;
        err_d                       = err_q;
        EN_start_writing_prt_entry  = 1'b0;
        EN_write_prt_entry          = 1'b0;
        EN_finish_writing_prt_entry = 1'b0;
        in_ready                    = 1'b0;
        wr_done_valid               = 1'b0;
        if (!RST) begin
            case (wr_state_q)
                W_IDLE: begin
                    // The first beat stays in the FIFO until a slot is opened.
                    EN_start_writing_prt_entry = in_valid & is_prt_slot_free &
                                                 RDY_is_prt_slot_free & RDY_start_writing_prt_entry;
                    if (EN_start_writing_prt_entry) begin
                        slot_d     = start_writing_prt_entry;
                        beat_cnt_d = '0;
                        err_d      = 1'b0;
                        wr_state_d = W_DATA;
                    end
                end
                W_DATA: begin
                    EN_write_prt_entry = in_valid & RDY_write_prt_entry;
                    in_ready           = EN_write_prt_entry;
                    if (EN_write_prt_entry) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (in_last) begin
                            wr_state_d = W_FINISH;
                        end else if (beat_cnt_q == BEAT_LIM) begin
                            err_d      = 1'b1;
                            wr_state_d = W_DRAIN;
                        end
                    end
                end
                W_DRAIN: begin
                    in_ready = 1'b1;
                    if (in_valid && in_last) begin
                        wr_state_d = W_FINISH;
                    end
                end
                W_FINISH: begin
                    EN_finish_writing_prt_entry = RDY_finish_writing_prt_entry;
                    if (EN_finish_writing_prt_entry) begin
                        wr_state_d = W_DONE;
                    end
                end
                W_DONE: begin
                    wr_done_valid = 1'b1;
                    if (wr_done_ready) begin
                        wr_state_d = W_IDLE;
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_state_q <= W_IDLE;
            slot_q     <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            slot_q     <= slot_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign write_prt_entry_data = in_data;
    assign wr_done_slot         = slot_q;
    assign wr_done_err          = err_q;

    // ---------------- read engine ----------------
    always_comb begin
        rd_state_d                 = rd_state_q;
        rd_slot_d                  = rd_slot_q;
        cmd_ready                  = 1'b0;
        EN_start_reading_prt_entry = 1'b0;
        EN_read_prt_entry          = 1'b0;
        EN_invalidate_prt_entry    = 1'b0;
        out_valid                  = 1'b0;
        cmd_done                   = 1'b0;
        if (!RST) begin
            case (rd_state_q)
                R_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        rd_slot_d  = cmd_slot;
                        rd_state_d = (cmd_drop == OP_DROP) ? R_INVAL : R_START;
                    end
                end
                R_START: begin
                    EN_start_reading_prt_entry = RDY_start_reading_prt_entry;
                    if (EN_start_reading_prt_entry) begin
                        rd_state_d = R_DATA;
                    end
                end
                R_DATA: begin
                    out_valid         = RDY_read_prt_entry;
                    EN_read_prt_entry = RDY_read_prt_entry & out_ready;
                    if (EN_read_prt_entry && read_prt_entry[DATA_WIDTH]) begin
                        rd_state_d = R_INVAL;
                    end
                end
                R_INVAL: begin
                    EN_invalidate_prt_entry = RDY_invalidate_prt_entry;
                    cmd_done                = EN_invalidate_prt_entry;
                    if (EN_invalidate_prt_entry) begin
                        rd_state_d = R_IDLE;
                    end
                end
                default: rd_state_d = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_state_q <= R_IDLE;
            rd_slot_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_slot_q  <= rd_slot_d;
        end
    end

    assign out_data                     = read_prt_entry[DATA_WIDTH-1:0];
    assign out_last                     = read_prt_entry[DATA_WIDTH];
    assign start_reading_prt_entry_slot = rd_slot_q;
    assign invalidate_prt_entry_slot    = rd_slot_q;

endmodule

// File: tb/tb_prt_txn_sequencer.sv
// Directed bench for prt_txn_sequencer; the bench plays the PRT and both FIFOs by hand.
module tb_prt_txn_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        wr_done_valid, wr_done_ready, wr_done_err;
    logic [3:0]  wr_done_slot;
    logic        cmd_valid, cmd_ready, cmd_drop;
    logic [3:0]  cmd_slot;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        cmd_done;
    logic        EN_start_writing_prt_entry, RDY_start_writing_prt_entry;
    logic [3:0]  start_writing_prt_entry;
    logic        EN_write_prt_entry, RDY_write_prt_entry;
    logic [31:0] write_prt_entry_data;
    logic        EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry;
    logic        EN_invalidate_prt_entry, RDY_invalidate_prt_entry;
    logic [3:0]  invalidate_prt_entry_slot;
    logic        EN_start_reading_prt_entry, RDY_start_reading_prt_entry;
    logic [3:0]  start_reading_prt_entry_slot;
    logic        EN_read_prt_entry, RDY_read_prt_entry;
    logic [32:0] read_prt_entry;
    logic        is_prt_slot_free, RDY_is_prt_slot_free;

    int checks = 0;
    int errors = 0;

    prt_txn_sequencer #(.DATA_WIDTH(32), .NUM_SLOTS(16), .MAX_BEATS(4)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .wr_done_valid(wr_done_valid), .wr_done_ready(wr_done_ready),
        .wr_done_slot(wr_done_slot), .wr_done_err(wr_done_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slot(cmd_slot), .cmd_drop(cmd_drop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cmd_done(cmd_done),
        .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
        .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
        .start_writing_prt_entry(start_writing_prt_entry),
        .EN_write_prt_entry(EN_write_prt_entry), .RDY_write_prt_entry(RDY_write_prt_entry),
        .write_prt_entry_data(write_prt_entry_data),
        .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
        .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
        .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
        .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
        .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
        .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
        .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
        .EN_read_prt_entry(EN_read_prt_entry), .RDY_read_prt_entry(RDY_read_prt_entry),
        .read_prt_entry(read_prt_entry),
        .is_prt_slot_free(is_prt_slot_free), .RDY_is_prt_slot_free(RDY_is_prt_slot_free)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2ns after the rising edge; checks sample 1ns later.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_en_low(input string tag);
        chk({tag, "_en_start_wr"}, EN_start_writing_prt_entry, 1'b0);
        chk({tag, "_en_write"},    EN_write_prt_entry, 1'b0);
        chk({tag, "_en_finish"},   EN_finish_writing_prt_entry, 1'b0);
        chk({tag, "_en_inval"},    EN_invalidate_prt_entry, 1'b0);
        chk({tag, "_en_start_rd"}, EN_start_reading_prt_entry, 1'b0);
        chk({tag, "_en_read"},     EN_read_prt_entry, 1'b0);
        chk({tag, "_in_ready"},    in_ready, 1'b0);
        chk({tag, "_out_valid"},   out_valid, 1'b0);
        chk({tag, "_cmd_ready"},   cmd_ready, 1'b0);
        chk({tag, "_cmd_done"},    cmd_done, 1'b0);
        chk({tag, "_wr_done_vld"}, wr_done_valid, 1'b0);
    endtask

    logic [32:0] rd_beats [4];
    int          rd_idx;
    int          wr_fires;
    logic        fired;

    initial begin
        RST = 1'b1;
        in_valid = 1'b1; in_data = 32'h0; in_last = 1'b0;
        wr_done_ready = 1'b0;
        cmd_valid = 1'b1; cmd_slot = 4'd0; cmd_drop = 1'b0;
        out_ready = 1'b1;
        RDY_start_writing_prt_entry = 1'b1; start_writing_prt_entry = 4'd0;
        RDY_write_prt_entry = 1'b1; RDY_finish_writing_prt_entry = 1'b1;
        RDY_invalidate_prt_entry = 1'b1; RDY_start_reading_prt_entry = 1'b1;
        RDY_read_prt_entry = 1'b1; read_prt_entry = 33'h0;
        is_prt_slot_free = 1'b1; RDY_is_prt_slot_free = 1'b1;

        // Reset: everything gated low even with requests pending.
        settle();
        chk_all_en_low("rst");
        chk("rst_slot", wr_done_slot, 4'd0);
        chk("rst_err", wr_done_err, 1'b0);
        tick(); tick();
        RST = 1'b0; in_valid = 1'b0; cmd_valid = 1'b0;
        settle();
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // Three-beat packet into slot 5.
        in_valid = 1'b1; in_data = 32'hA1; start_writing_prt_entry = 4'd5;
        settle();
        chk("p3_en_start", EN_start_writing_prt_entry, 1'b1);
        chk("p3_start_no_consume", in_ready, 1'b0);
        tick();
        settle();
        chk("p3_b1_en", EN_write_prt_entry, 1'b1);
        chk("p3_b1_rdy", in_ready, 1'b1);
        chk("p3_b1_dat", write_prt_entry_data, 32'hA1);
        tick();
        in_data = 32'hA2; settle();
        chk("p3_b2_en", EN_write_prt_entry, 1'b1);
        chk("p3_b2_dat", write_prt_entry_data, 32'hA2);
        tick();
        in_data = 32'hA3; in_last = 1'b1; settle();
        chk("p3_b3_en", EN_write_prt_entry, 1'b1);
        chk("p3_b3_dat", write_prt_entry_data, 32'hA3);
        tick();
        in_valid = 1'b0; in_last = 1'b0; settle();
        chk("p3_finish", EN_finish_writing_prt_entry, 1'b1);
        chk("p3_no_write", EN_write_prt_entry, 1'b0);
        chk("p3_no_done_yet", wr_done_valid, 1'b0);
        tick();
        settle();
        chk("p3_done_vld", wr_done_valid, 1'b1);
        chk("p3_done_slot", wr_done_slot, 4'd5);
        chk("p3_done_err", wr_done_err, 1'b0);
        chk("p3_done_no_finish", EN_finish_writing_prt_entry, 1'b0);
        wr_done_ready = 1'b1;
        tick();
        wr_done_ready = 1'b0; settle();
        chk("p3_done_clr", wr_done_valid, 1'b0);

        // Forward slot 5.
        cmd_valid = 1'b1; cmd_slot = 4'd5; cmd_drop = 1'b0; settle();
        chk("fwd_cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0; settle();
        chk("fwd_start_en", EN_start_reading_prt_entry, 1'b1);
        chk("fwd_start_slot", start_reading_prt_entry_slot, 4'd5);
        chk("fwd_busy", cmd_ready, 1'b0);
        chk("fwd_no_read_yet", EN_read_prt_entry, 1'b0);
        tick();
        read_prt_entry = {1'b0, 32'hA1}; settle();
        chk("fwd_b1_vld", out_valid, 1'b1);
        chk("fwd_b1_dat", out_data, 32'hA1);
        chk("fwd_b1_last", out_last, 1'b0);
        chk("fwd_b1_en", EN_read_prt_entry, 1'b1);
        tick();
        read_prt_entry = {1'b0, 32'hA2}; settle();
        chk("fwd_b2_dat", out_data, 32'hA2);
        chk("fwd_b2_en", EN_read_prt_entry, 1'b1);
        tick();
        read_prt_entry = {1'b1, 32'hA3}; settle();
        chk("fwd_b3_dat", out_data, 32'hA3);
        chk("fwd_b3_last", out_last, 1'b1);
        chk("fwd_b3_en", EN_read_prt_entry, 1'b1);
        tick();
        read_prt_entry = 33'h0; settle();
        chk("fwd_inval_en", EN_invalidate_prt_entry, 1'b1);
        chk("fwd_inval_slot", invalidate_prt_entry_slot, 4'd5);
        chk("fwd_cmd_done", cmd_done, 1'b1);
        chk("fwd_inval_no_read", EN_read_prt_entry, 1'b0);
        chk("fwd_inval_no_vld", out_valid, 1'b0);
        tick();
        settle();
        chk("fwd_done_pulse", cmd_done, 1'b0);
        chk("fwd_back_idle", cmd_ready, 1'b1);

        // Drop slot 7: invalidate one cycle after accept, no read activity.
        cmd_valid = 1'b1; cmd_slot = 4'd7; cmd_drop = 1'b1; settle();
        chk("drop_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0; cmd_drop = 1'b0; settle();
        chk("drop_no_start", EN_start_reading_prt_entry, 1'b0);
        chk("drop_no_read", EN_read_prt_entry, 1'b0);
        chk("drop_inval_en", EN_invalidate_prt_entry, 1'b1);
        chk("drop_inval_slot", invalidate_prt_entry_slot, 4'd7);
        chk("drop_cmd_done", cmd_done, 1'b1);
        tick();
        settle();
        chk("drop_inval_clr", EN_invalidate_prt_entry, 1'b0);

        // Six-beat packet with MAX_BEATS=4: 4 written, 2 drained, error flagged.
        in_valid = 1'b1; in_data = 32'hB1; in_last = 1'b0; start_writing_prt_entry = 4'd9;
        settle();
        chk("p6_en_start", EN_start_writing_prt_entry, 1'b1);
        tick();
        wr_fires = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'hB1 + i; in_last = (i == 5); settle();
            chk("p6_in_ready", in_ready, 1'b1);
            chk("p6_en_write", EN_write_prt_entry, (i < 4) ? 1'b1 : 1'b0);
            if (EN_write_prt_entry) wr_fires++;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; settle();
        chk("p6_write_count", wr_fires, 4);
        chk("p6_finish", EN_finish_writing_prt_entry, 1'b1);
        tick();
        settle();
        chk("p6_done_vld", wr_done_valid, 1'b1);
        chk("p6_done_slot", wr_done_slot, 4'd9);
        chk("p6_done_err", wr_done_err, 1'b1);
        wr_done_ready = 1'b1; tick(); wr_done_ready = 1'b0;

        // Exactly MAX_BEATS beats ending in last: no error.
        in_valid = 1'b1; in_data = 32'hE0; start_writing_prt_entry = 4'd3; settle();
        chk("p4_en_start", EN_start_writing_prt_entry, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hE1 + i; in_last = (i == 3); settle();
            chk("p4_en_write", EN_write_prt_entry, 1'b1);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; settle();
        chk("p4_finish", EN_finish_writing_prt_entry, 1'b1);
        tick();
        settle();
        chk("p4_done_slot", wr_done_slot, 4'd3);
        chk("p4_done_err", wr_done_err, 1'b0);
        wr_done_ready = 1'b1; tick(); wr_done_ready = 1'b0;

        // No slot free for 10 cycles with a beat waiting.
        in_valid = 1'b1; in_data = 32'hD1; in_last = 1'b1;
        is_prt_slot_free = 1'b0; start_writing_prt_entry = 4'd2;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("nofree_en_start", EN_start_writing_prt_entry, 1'b0);
            chk("nofree_in_ready", in_ready, 1'b0);
            tick();
        end
        is_prt_slot_free = 1'b1; settle();
        chk("free_en_start", EN_start_writing_prt_entry, 1'b1);
        tick();
        RDY_write_prt_entry = 1'b0; settle();
        chk("wrstall_in_ready", in_ready, 1'b0);
        chk("wrstall_en_write", EN_write_prt_entry, 1'b0);
        tick();
        RDY_write_prt_entry = 1'b1; settle();
        chk("wrstall_resume_en", EN_write_prt_entry, 1'b1);
        chk("wrstall_resume_dat", write_prt_entry_data, 32'hD1);
        tick();
        in_valid = 1'b0; in_last = 1'b0; settle();
        chk("p1_finish", EN_finish_writing_prt_entry, 1'b1);
        tick();
        settle();
        chk("p1_done_slot", wr_done_slot, 4'd2);
        wr_done_ready = 1'b1; tick(); wr_done_ready = 1'b0;

        // Forward slot 2 with out_ready toggling, then reset mid-read.
        rd_beats[0] = {1'b0, 32'hC1};
        rd_beats[1] = {1'b0, 32'hC2};
        rd_beats[2] = {1'b0, 32'hC3};
        rd_beats[3] = {1'b1, 32'hC4};
        cmd_valid = 1'b1; cmd_slot = 4'd2; cmd_drop = 1'b0; settle();
        chk("tog_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0; settle();
        chk("tog_start", EN_start_reading_prt_entry, 1'b1);
        tick();
        rd_idx = 0;
        for (int c = 0; c < 4; c++) begin
            out_ready = (c % 2 == 0);
            read_prt_entry = rd_beats[rd_idx]; settle();
            chk("tog_out_vld", out_valid, 1'b1);
            chk("tog_out_dat", out_data, rd_beats[rd_idx][31:0]);
            chk("tog_en_read", EN_read_prt_entry, out_ready);
            fired = EN_read_prt_entry;
            tick();
            if (fired) rd_idx++;
        end
        chk("tog_beats_emitted", rd_idx, 2);
        read_prt_entry = rd_beats[rd_idx];
        RST = 1'b1; out_ready = 1'b1; settle();
        chk_all_en_low("midrst");
        tick(); tick();
        RST = 1'b0; settle();
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_out_vld", out_valid, 1'b0);
        chk("post_rst_en_read", EN_read_prt_entry, 1'b0);
        chk("post_rst_en_inval", EN_invalidate_prt_entry, 1'b0);
        chk("post_rst_wr_done", wr_done_valid, 1'b0);
        chk("post_rst_slot", wr_done_slot, 4'd0);
        in_valid = 1'b1; is_prt_slot_free = 1'b1; settle();
        chk("post_rst_wr_idle", EN_start_writing_prt_entry, 1'b1);
        chk("post_rst_no_consume", in_ready, 1'b0);
        in_valid = 1'b0; settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
